// File: rtl/sync_r2w_status_if.sv
// Write-side status bundle for the async FIFO: read-pointer input, push controls and
// write-domain pointer/flag outputs.
interface sync_r2w_status_if #(
    parameter int unsigned address_size = 3
);
    logic [address_size:0]   read_pointer;
    logic                    write_increment;
    logic                    write_overflow_clear;
    logic [address_size:0]   write_to_read_pointer;
    logic [address_size:0]   write_pointer;
    logic [address_size-1:0] write_address;
    logic                    write_full;
    logic                    write_almost_full;
    logic [address_size:0]   write_level;
    logic                    write_overflow;

    modport master (
        output read_pointer,
        output write_increment,
        output write_overflow_clear,
        input  write_to_read_pointer,
        input  write_pointer,
        input  write_address,
        input  write_full,
        input  write_almost_full,
        input  write_level,
        input  write_overflow
    );

    modport slave (
        input  read_pointer,
        input  write_increment,
        input  write_overflow_clear,
        output write_to_read_pointer,
        output write_pointer,
        output write_address,
        output write_full,
        output write_almost_full,
        output write_level,
        output write_overflow
    );
endinterface

// File: rtl/sync_r2w_status.sv
// Write-domain side of the async FIFO: read-pointer synchroniser, write pointer ownership
// and registered full / almost-full / level / sticky overflow status.
module sync_r2w_status #(
    parameter int unsigned address_size      = 3,
    parameter int unsigned sync_stages       = 2,
    parameter int unsigned almost_full_level = 6
) (
    input logic              write_clk,
    input logic              write_reset_n,
    sync_r2w_status_if.slave status
);

    localparam int unsigned PtrWidth = address_size + 1;
    // Full when the write gray pointer equals the read gray pointer with its top two bits flipped.
    localparam logic [PtrWidth-1:0] FullMask = PtrWidth'(3) << (PtrWidth - 2);

    if (sync_stages < 2 || sync_stages > 4) begin : g_bad_sync_stages
        $error("sync_stages must be in 2..4");
    end
    if (almost_full_level < 1 || almost_full_level > (1 << address_size)) begin : g_bad_af_level
        $error("almost_full_level must be in 1..2^address_size");
    end

    function automatic logic [PtrWidth-1:0] gray_to_bin(input logic [PtrWidth-1:0] gray);
        logic [PtrWidth-1:0] bin;
        bin[PtrWidth-1] = gray[PtrWidth-1];
        for (int i = int'(PtrWidth) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    logic [PtrWidth-1:0] sync_q [sync_stages];
    logic [PtrWidth-1:0] wbin_q, wbin_d;
    logic [PtrWidth-1:0] wgray_q, wgray_d;
    logic [PtrWidth-1:0] level_q, level_d;
    logic                full_q, full_d;
    logic                almost_full_q, almost_full_d;
    logic                overflow_q, overflow_d;

    logic [PtrWidth-1:0] synced_gray;
    logic [PtrWidth-1:0] rbin;
    logic                accept;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            for (int i = 0; i < int'(sync_stages); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= status.read_pointer;
            for (int i = 1; i < int'(sync_stages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced_gray = sync_q[sync_stages-1];
    assign rbin        = gray_to_bin(synced_gray);

    always_comb begin
        accept        = status.write_increment & ~full_q;
        wbin_d        = wbin_q + PtrWidth'(accept);
        wgray_d       = wbin_d ^ (wbin_d >> 1);
        full_d        = (wgray_d == (synced_gray ^ FullMask));
        level_d       = wbin_d - rbin;
        almost_full_d = (level_d >= PtrWidth'(almost_full_level));
        // A rejected push on the same edge as a clear keeps the flag set.
        overflow_d    = (status.write_increment & full_q) |
                        (overflow_q & ~status.write_overflow_clear);
    end

    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wgray_q       <= wgray_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign status.write_to_read_pointer = synced_gray;
    assign status.write_pointer         = wgray_q;
    assign status.write_address         = wbin_q[address_size-1:0];
    assign status.write_full            = full_q;
    assign status.write_almost_full     = almost_full_q;
    assign status.write_level           = level_q;
    assign status.write_overflow        = overflow_q;

endmodule

// File: tb/tb_sync_r2w_status.sv
// Directed bench for sync_r2w_status: a 2-stage and a 3-stage instance driven side by side.
module tb_sync_r2w_status;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    sync_r2w_status_if #(.address_size(3)) if2 ();
    sync_r2w_status_if #(.address_size(3)) if3 ();

    sync_r2w_status #(
        .address_size(3),
        .sync_stages(2),
        .almost_full_level(6)
    ) u_dut2 (
        .write_clk(clk),
        .write_reset_n(rst_n),
        .status(if2)
    );

    sync_r2w_status #(
        .address_size(3),
        .sync_stages(3),
        .almost_full_level(6)
    ) u_dut3 (
        .write_clk(clk),
        .write_reset_n(rst_n),
        .status(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic inc, input logic clr);
        if2.write_increment      = inc;
        if3.write_increment      = inc;
        if2.write_overflow_clear = clr;
        if3.write_overflow_clear = clr;
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wp2"}, 32'(if2.write_pointer), 0);
        check({tag, "_wa2"}, 32'(if2.write_address), 0);
        check({tag, "_lvl2"}, 32'(if2.write_level), 0);
        check({tag, "_full2"}, 32'(if2.write_full), 0);
        check({tag, "_af2"}, 32'(if2.write_almost_full), 0);
        check({tag, "_ovf2"}, 32'(if2.write_overflow), 0);
        check({tag, "_sync2"}, 32'(if2.write_to_read_pointer), 0);
        check({tag, "_lvl3"}, 32'(if3.write_level), 0);
        check({tag, "_wp3"}, 32'(if3.write_pointer), 0);
        check({tag, "_sync3"}, 32'(if3.write_to_read_pointer), 0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        if2.read_pointer = '0;
        if3.read_pointer = '0;
        set_push(1'b0, 1'b0);
        #1;
        check_all_zero("reset");

        // Fill: 8 pushes with the read pointer parked at 0.
        set_push(1'b1, 1'b0);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("fill_lvl2", 32'(if2.write_level), 32'(i));
            check("fill_af2", 32'(if2.write_almost_full), (i >= 6) ? 1 : 0);
            check("fill_full2", 32'(if2.write_full), (i == 8) ? 1 : 0);
            check("fill_lvl3", 32'(if3.write_level), 32'(i));
        end
        check("fill_wp2", 32'(if2.write_pointer), 32'b1100);
        check("fill_wa2", 32'(if2.write_address), 0);
        check("fill_full3", 32'(if3.write_full), 1);

        // Overflow behaviour.
        step();
        check("ovf_wp_hold", 32'(if2.write_pointer), 32'b1100);
        check("ovf_lvl_hold", 32'(if2.write_level), 8);
        check("ovf_set", 32'(if2.write_overflow), 1);
        set_push(1'b0, 1'b0);
        step();
        check("ovf_sticky", 32'(if2.write_overflow), 1);
        set_push(1'b0, 1'b1);
        step();
        check("ovf_clear", 32'(if2.write_overflow), 0);
        set_push(1'b1, 1'b0);
        step();
        check("ovf_reset", 32'(if2.write_overflow), 1);
        set_push(1'b1, 1'b1);
        step();
        check("ovf_set_wins", 32'(if2.write_overflow), 1);
        check("ovf_set_wins3", 32'(if3.write_overflow), 1);
        set_push(1'b0, 1'b1);
        step();
        check("ovf_clear2", 32'(if2.write_overflow), 0);
        set_push(1'b0, 1'b0);

        // Drain: reader reports binary 3 (gray 0010).
        if2.read_pointer = 4'b0010;
        if3.read_pointer = 4'b0010;
        step();
        step();
        check("drain_sync2", 32'(if2.write_to_read_pointer), 32'b0010);
        check("drain_full2_hold", 32'(if2.write_full), 1);
        check("drain_sync3_early", 32'(if3.write_to_read_pointer), 0);
        step();
        check("drain_full2", 32'(if2.write_full), 0);
        check("drain_lvl2", 32'(if2.write_level), 5);
        check("drain_af2", 32'(if2.write_almost_full), 0);
        check("drain_sync3", 32'(if3.write_to_read_pointer), 32'b0010);
        check("drain_full3_hold", 32'(if3.write_full), 1);
        step();
        check("drain_full3", 32'(if3.write_full), 0);
        check("drain_lvl3", 32'(if3.write_level), 5);
        check("drain_af3", 32'(if3.write_almost_full), 0);

        // Asynchronous reset mid-cycle while level is 5.
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("areset");

        // Wrap: reader trails 4 behind; drive ahead by the sync depth.
        if2.read_pointer = '0;
        if3.read_pointer = '0;
        set_push(1'b1, 1'b0);
        #1 rst_n = 1'b1;
        for (int m = 1; m <= 20; m++) begin
            if2.read_pointer = gray((m > 2) ? m - 2 : 0);
            if3.read_pointer = gray((m > 1) ? m - 1 : 0);
            step();
            check("wrap_lvl2", 32'(if2.write_level), (m < 4) ? 32'(m) : 4);
            check("wrap_lvl3", 32'(if3.write_level), (m < 4) ? 32'(m) : 4);
            check("wrap_full2", 32'(if2.write_full), 0);
            check("wrap_full3", 32'(if3.write_full), 0);
            check("wrap_wp2", 32'(if2.write_pointer), 32'(gray(m)));
            check("wrap_wa3", 32'(if3.write_address), 32'(m % 8));
        end
        check("wrap_af2", 32'(if2.write_almost_full), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_r2w_status.md
# sync_r2w_status

Parametrised write-side status block for the asynchronous FIFO. It synchronises the gray-coded read pointer into the write clock domain through a configurable-depth flop chain. It owns the write pointer (binary and gray) and produces registered full, almost-full, fill-level and sticky overflow indications for the write port. It generalises the fixed two-flop read-to-write pointer synchroniser with selectable stage count, pointer ownership and status generation.

## Interface
- address_size, 3, FIFO address width; depth = 2^address_size; pointers are address_size+1 bits
- sync_stages, 2, synchroniser flop count; legal range 2..4
- almost_full_level, 6, level at or above which write_almost_full asserts; legal range 1..2^address_size

- write_clk  input  1  write-domain clock, all flops rising-edge
- write_reset_n  input  1  asynchronous active-low reset
- read_pointer  input  address_size+1  gray-coded read pointer from read domain (asynchronous to write_clk)
- write_increment  input  1  push request
- write_overflow_clear  input  1  clears write_overflow
- write_to_read_pointer  output  address_size+1  synchronised gray read pointer (last sync stage)
- write_pointer  output  address_size+1  registered gray write pointer, to read-domain synchroniser
- write_address  output  address_size  RAM write address = low address_size bits of binary write pointer
- write_full  output  1  registered full flag
- write_almost_full  output  1  registered almost-full flag
- write_level  output  address_size+1  registered fill level, 0..2^address_size
- write_overflow  output  1  sticky: push attempted while full

## Operation
- Sync chain: sync_stages flops, stage 0 samples read_pointer; no logic between stages; write_to_read_pointer = final stage.
- rbin = gray-to-binary of write_to_read_pointer (XOR-prefix from MSB).
- accept = write_increment & ~write_full. wbin_next = wbin + accept, modulo 2^(address_size+1); wgray_next = wbin_next ^ (wbin_next >> 1).
- write_full next = (wgray_next == {~write_to_read_pointer[MSB:MSB-1], write_to_read_pointer[MSB-2:0]}).
- write_level next = (wbin_next - rbin) modulo 2^(address_size+1).
- write_almost_full next = (write_level next >= almost_full_level).
- write_overflow: set when write_increment & write_full; cleared by write_overflow_clear; set wins on same edge.
- Push while full: ignored; pointers and level unchanged.
- Wrap-around: pointers roll from 2^(address_size+1)-1 to 0; full/level arithmetic stays correct across the wrap.
- Read pointer advancing several steps between samples: level and flags follow the newest synchronised value; no error is raised.

## Timing
- Reset (asynchronous, immediate, independent of write_clk): all sync stages, write_pointer, write_address, write_level = 0; write_full, write_almost_full, write_overflow = 0.
- Reset deassertion: first accepted push is on the first rising edge with write_reset_n high.
- Push: write_pointer, write_address, write_level, write_full, write_almost_full update on the same edge that accepts the push (latency 1).
- Read-pointer change stable before edge k appears on write_to_read_pointer after edge k+sync_stages-1; flags and level reflect it after edge k+sync_stages.
- write_full is pessimistic: it deasserts only after the synchronised read pointer shows the pop.
- write_overflow: set on the edge following a rejected push; cleared on the edge sampling write_overflow_clear (unless a set occurs on that edge).

## Test plan
- Reset: drive write_reset_n=0 mid-cycle with write_level=5 -> all outputs 0 immediately, before the next edge.
- Fill (address_size=3, read_pointer=4'b0000, 8 pushes): write_level steps 1..8; write_almost_full rises with level 6; write_full rises on the 8th accept edge; write_pointer=4'b1100, write_address=3'b000.
- Overflow: push while full -> write_pointer stays 4'b1100; write_overflow=1 next edge and holds; pulse write_overflow_clear -> 0; simultaneous clear and rejected push -> stays 1.
- Drain sync latency (sync_stages=2): from full, set read_pointer=4'b0010 (binary 3) -> write_to_read_pointer=4'b0010 two edges later; one edge after that write_full=0, write_level=5, write_almost_full=0.
- Wrap: 20 pushes with read_pointer tracking the write pointer 4 behind -> write_pointer passes 4'b1000 (bin 15) to 4'b0000; write_level constant 4; write_full never set.
- sync_stages=3 instance: repeat the drain test -> write_to_read_pointer updates three edges after the change; flags update on the fourth edge.
